// File: rtl/awb_gain_ctrl.sv
// ============================================================================
// Module   : awb_gain_ctrl
// Purpose  : Auto-white-balance controller. Taps the Bayer stream feeding the
//            white-balance gain stage, accumulates per-channel sums over a
//            frame, and at frame end runs a sequential restoring divider to
//            derive red/blue gains relative to green (gain = G/2 * 128 / C,
//            Q1.7, saturated to 0xFF). New gains are held pending and applied
//            only on the next frameStart, so a frame is never gained
//            inconsistently.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock
//   rst_n        in   1   asynchronous reset, active-low
//   Din          in  16   {pixel[11:0], bayerId[3:0]}; bit1 blue, else bit2 red,
//                         else green
//   dataEn       in   1   Din valid this cycle
//   frameStart   in   1   pulse on first cycle of a frame
//   frameEnd     in   1   pulse on last cycle of a frame
//   awbEn        in   1   1 = automatic gains, 0 = manual gains
//   manRedGain   in   8   manual red gain
//   manGreGain   in   8   manual green gain
//   manBluGain   in   8   manual blue gain
//   redGain      out  8   applied red gain
//   greGain      out  8   applied green gain
//   bluGain      out  8   applied blue gain
//   busy         out  1   divider sequencer active
//   gainValid    out  1   one-cycle pulse when a new auto gain set is pending
// ============================================================================
`default_nettype none

module awb_gain_ctrl #(
    parameter int         SUM_W = 34,
    parameter logic [7:0] UNITY = 8'h80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Din,
    input  logic        dataEn,
    input  logic        frameStart,
    input  logic        frameEnd,
    input  logic        awbEn,
    input  logic [7:0]  manRedGain,
    input  logic [7:0]  manGreGain,
    input  logic [7:0]  manBluGain,
    output logic [7:0]  redGain,
    output logic [7:0]  greGain,
    output logic [7:0]  bluGain,
    output logic        busy,
    output logic        gainValid
);

    // Divider datapath width: numerator gT*128 and divisor*256 both fit here.
    localparam int               c_DIV_W     = SUM_W + 8;
    localparam logic [SUM_W-1:0] c_SUM_MAX   = '1;
    localparam logic [3:0]       c_LAST_STEP = 4'd8;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LATCH = 3'd1;
    localparam logic [2:0] c_DIV_R = 3'd2;
    localparam logic [2:0] c_DIV_B = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    // ------------------------------------------------------------------
    // Site decode (index 0 = red, 1 = green, 2 = blue)
    // ------------------------------------------------------------------
    logic [11:0] w_pixel;
    logic [2:0]  w_site;
    logic        w_unused_din;

    assign w_pixel      = Din[15:4];
    assign w_unused_din = ^{Din[3], Din[0]};

    always_comb begin
        w_site = 3'b000;
        if (Din[1])      w_site[2] = 1'b1;
        else if (Din[2]) w_site[0] = 1'b1;
        else             w_site[1] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-channel saturating accumulators
    // ------------------------------------------------------------------
    logic [2:0][SUM_W-1:0] w_sum;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_acc
            logic [SUM_W-1:0] r_acc;
            logic [SUM_W:0]   w_add;
            logic [SUM_W-1:0] w_sat;

            assign w_add = {1'b0, r_acc} + {{(SUM_W-11){1'b0}}, w_pixel};
            assign w_sat = w_add[SUM_W] ? c_SUM_MAX : w_add[SUM_W-1:0];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (frameStart) begin
                    // Clear-then-add: a pixel on the frameStart cycle seeds the sum.
                    r_acc <= (dataEn && w_site[g]) ? {{(SUM_W-12){1'b0}}, w_pixel} : '0;
                end else if (dataEn && w_site[g]) begin
                    r_acc <= w_sat;
                end
            end

            assign w_sum[g] = r_acc;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Divider sequencer
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [3:0]         r_cnt;
    logic [SUM_W-1:0]   r_gT;
    logic [SUM_W-1:0]   r_dR;
    logic [SUM_W-1:0]   r_dB;
    logic [c_DIV_W-1:0] r_rem;
    logic [c_DIV_W-1:0] r_dsh;
    logic [7:0]         r_q;
    logic               r_hold;   // quotient forced (zero divisor / overflow)
    logic [7:0]         r_qR;

    logic [SUM_W-1:0]   w_div;
    logic [c_DIV_W-1:0] w_num;
    logic [c_DIV_W-1:0] w_dsh8;
    logic               w_ovf;
    logic               w_ge;
    logic [7:0]         w_q_step;

    // Red and blue share one datapath; only the divisor differs.
    assign w_div    = (r_state == c_DIV_R) ? r_dR : r_dB;
    assign w_num    = {1'b0, r_gT, 7'b0};
    assign w_dsh8   = {w_div, 8'b0};
    assign w_ovf    = (w_num >= w_dsh8);
    assign w_ge     = (r_rem >= r_dsh);
    assign w_q_step = r_hold ? r_q : {r_q[6:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_gT    <= '0;
            r_dR    <= '0;
            r_dB    <= '0;
            r_rem   <= '0;
            r_dsh   <= '0;
            r_q     <= '0;
            r_hold  <= 1'b0;
            r_qR    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (frameEnd && awbEn) r_state <= c_LATCH;
                end
                c_LATCH: begin
                    // Sums already include any pixel coincident with frameEnd.
                    r_gT    <= w_sum[1] >> 1;
                    r_dR    <= w_sum[0];
                    r_dB    <= w_sum[2];
                    r_cnt   <= '0;
                    r_state <= c_DIV_R;
                end
                c_DIV_R, c_DIV_B: begin
                    if (r_cnt == 4'd0) begin
                        // Range check: a quotient >= 256 saturates; a zero
                        // divisor yields unity. Both bypass the bit steps.
                        r_rem <= w_num;
                        r_dsh <= {1'b0, w_div, 7'b0};
                        if (w_div == '0) begin
                            r_q    <= UNITY;
                            r_hold <= 1'b1;
                        end else if (w_ovf) begin
                            r_q    <= 8'hFF;
                            r_hold <= 1'b1;
                        end else begin
                            r_q    <= 8'h00;
                            r_hold <= 1'b0;
                        end
                    end else begin
                        // Restoring step, quotient bits MSB first.
                        if (w_ge && !r_hold) r_rem <= r_rem - r_dsh;
                        r_dsh <= r_dsh >> 1;
                        r_q   <= w_q_step;
                    end

                    if (r_cnt == c_LAST_STEP) begin
                        r_cnt <= '0;
                        if (r_state == c_DIV_R) begin
                            r_qR    <= w_q_step;
                            r_state <= c_DIV_B;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending gains and frame-synchronous application
    // ------------------------------------------------------------------
    logic [7:0] r_pend_r;
    logic [7:0] r_pend_g;
    logic [7:0] r_pend_b;
    logic       r_pend_flag;
    logic [7:0] r_red_gain;
    logic [7:0] r_gre_gain;
    logic [7:0] r_blu_gain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_r    <= UNITY;
            r_pend_g    <= UNITY;
            r_pend_b    <= UNITY;
            r_pend_flag <= 1'b0;
            r_red_gain  <= UNITY;
            r_gre_gain  <= UNITY;
            r_blu_gain  <= UNITY;
        end else begin
            if (frameStart) begin
                if (!awbEn) begin
                    r_red_gain <= manRedGain;
                    r_gre_gain <= manGreGain;
                    r_blu_gain <= manBluGain;
                end else if (r_pend_flag) begin
                    r_red_gain  <= r_pend_r;
                    r_gre_gain  <= r_pend_g;
                    r_blu_gain  <= r_pend_b;
                    r_pend_flag <= 1'b0;
                end
            end
            // Placed after the apply so a fresh result is never lost and
            // never applied on the same frameStart it coincides with.
            if (r_state == c_DONE) begin
                r_pend_r    <= r_qR;
                r_pend_g    <= UNITY;
                r_pend_b    <= r_q;
                r_pend_flag <= 1'b1;
            end
        end
    end

    assign redGain   = r_red_gain;
    assign greGain   = r_gre_gain;
    assign bluGain   = r_blu_gain;
    assign busy      = (r_state != c_IDLE);
    assign gainValid = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_awb_gain_ctrl.sv
// ============================================================================
// Module   : tb_awb_gain_ctrl
// Purpose  : Self-checking bench for awb_gain_ctrl: directed frames with
//            hand-computed gains, then randomized frames compared every cycle
//            against a frame-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_awb_gain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Din = '0;
    logic        dataEn = 1'b0;
    logic        frameStart = 1'b0;
    logic        frameEnd = 1'b0;
    logic        awbEn = 1'b0;
    logic [7:0]  manRedGain = '0;
    logic [7:0]  manGreGain = '0;
    logic [7:0]  manBluGain = '0;
    logic [7:0]  redGain;
    logic [7:0]  greGain;
    logic [7:0]  bluGain;
    logic        busy;
    logic        gainValid;

    always #5 clk = ~clk;

    awb_gain_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Din        (Din),
        .dataEn     (dataEn),
        .frameStart (frameStart),
        .frameEnd   (frameEnd),
        .awbEn      (awbEn),
        .manRedGain (manRedGain),
        .manGreGain (manGreGain),
        .manBluGain (manBluGain),
        .redGain    (redGain),
        .greGain    (greGain),
        .bluGain    (bluGain),
        .busy       (busy),
        .gainValid  (gainValid)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: sums as plain integers; a frameEnd accepted at
    // edge t0 yields busy for the 20 cycles after it, gainValid on the
    // last of them, and pending gains from integer division.
    // ------------------------------------------------------------------
    localparam longint SUM_MAX = (64'd1 << 34) - 1;

    longint     m_sum [3] = '{0, 0, 0};
    int         m_t  = 0;
    int         m_t0 = -100;
    int         m_qR = 128;
    int         m_qB = 128;
    logic [7:0] m_red = 8'h80, m_gre = 8'h80, m_blu = 8'h80;
    logic [7:0] m_pR = 8'h80, m_pG = 8'h80, m_pB = 8'h80;
    bit         m_pf = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_gv = 1'b0;
    bit         m_idle;
    int         m_site;

    function automatic int quot(input longint g, input longint d);
        longint v;
        if (d == 0) return 128;
        v = (g * 128) / d;
        return (v > 255) ? 255 : int'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) m_sum[c] = 0;
            m_t = 0; m_t0 = -100;
            m_red = 8'h80; m_gre = 8'h80; m_blu = 8'h80;
            m_pR = 8'h80; m_pG = 8'h80; m_pB = 8'h80;
            m_pf = 1'b0; m_busy = 1'b0; m_gv = 1'b0;
        end else begin
            m_idle = !(m_t >= m_t0 + 1 && m_t <= m_t0 + 20);
            if (frameStart) begin
                if (!awbEn) begin
                    m_red = manRedGain; m_gre = manGreGain; m_blu = manBluGain;
                end else if (m_pf) begin
                    m_red = m_pR; m_gre = m_pG; m_blu = m_pB; m_pf = 1'b0;
                end
            end
            if (m_t == m_t0 + 20) begin
                m_pR = 8'(m_qR); m_pG = 8'h80; m_pB = 8'(m_qB); m_pf = 1'b1;
            end
            if (frameStart) for (int c = 0; c < 3; c++) m_sum[c] = 0;
            if (dataEn) begin
                m_site = Din[1] ? 2 : (Din[2] ? 0 : 1);
                m_sum[m_site] = m_sum[m_site] + longint'(Din[15:4]);
                if (m_sum[m_site] > SUM_MAX) m_sum[m_site] = SUM_MAX;
            end
            if (frameEnd && awbEn && m_idle) begin
                m_t0 = m_t;
                m_qR = quot(m_sum[1] / 2, m_sum[0]);
                m_qB = quot(m_sum[1] / 2, m_sum[2]);
            end
            m_busy = (m_t >= m_t0 && m_t <= m_t0 + 19);
            m_gv   = (m_t == m_t0 + 19);
            m_t++;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("model_gains", {8'h0, redGain, greGain, bluGain}, {8'h0, m_red, m_gre, m_blu});
            check("model_status", {30'h0, busy, gainValid}, {30'h0, m_busy, m_gv});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // site: 0 red, 1 green (gr), 2 blue, 3 green (gb)
    function automatic logic [15:0] px(input int site, input int v);
        logic [31:0] vv;
        logic [3:0]  b;
        vv = v;
        case (site)
            0:       b = 4'b0100;
            2:       b = 4'b0010;
            3:       b = 4'b1000;
            default: b = 4'b0001;
        endcase
        return {vv[11:0], b};
    endfunction

    task automatic step(input bit fs, input bit fe, input bit de, input logic [15:0] d);
        @(negedge clk);
        frameStart = fs; frameEnd = fe; dataEn = de; Din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic pixels(input int n, input int site, input int v);
        repeat (n) step(1'b0, 1'b0, 1'b1, px(site, v));
    endtask

    // Called right after the frameEnd step; counts cycles until gainValid.
    task automatic wait_gv(input string name);
        int k;
        k = 0;
        while (!gainValid && k < 40) begin
            idle(1);
            k++;
        end
        check(name, k, 20);
    endtask

    task automatic std_frame(input int r, input int g, input int b);
        pixels(4, 0, r);
        pixels(4, 1, g);
        pixels(4, 3, g);
        pixels(4, 2, b);
        step(1'b0, 1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n_gv;
        bit seen;
        int len;
        int gap;

        // 1. reset state; frameEnd with awbEn = 0 is ignored
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("reset_gains", {8'h0, redGain, greGain, bluGain}, 32'h0080_8080);
        check("reset_status", {30'h0, busy, gainValid}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        seen = 1'b0;
        repeat (25) begin
            idle(1);
            if (busy || gainValid) seen = 1'b1;
        end
        check("awb_off_frameend_ignored", {31'h0, seen}, 32'h0);

        // 2. R=2000, G=1000, B=4000 -> 0x40 / 0x80 / 0x20
        awbEn = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        std_frame(2000, 1000, 4000);
        wait_gv("gv_latency_t2");
        idle(3);
        check("gains_hold_until_fs", {8'h0, redGain, greGain, bluGain}, 32'h0080_8080);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("gains_t2", {8'h0, redGain, greGain, bluGain}, 32'h0040_8020);

        // 3. R=100 saturates, B=0 gives unity
        pixels(4, 0, 100);
        pixels(8, 1, 1000);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        wait_gv("gv_latency_t3");
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("gains_t3", {8'h0, redGain, greGain, bluGain}, 32'h00ff_8080);

        // 4. frameEnd while busy ignored; frameStart during DIV_B holds gains
        std_frame(4000, 1000, 1000);
        n_gv = 0;
        for (int i = 1; i <= 40; i++) begin
            step(i == 13, i == 5, 1'b0, 16'h0);
            if (gainValid) n_gv++;
        end
        check("single_gv_t4", n_gv, 1);
        check("gains_unchanged_t4", {8'h0, redGain, greGain, bluGain}, 32'h00ff_8080);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("gains_t4", {8'h0, redGain, greGain, bluGain}, 32'h0020_8080);

        // 5. manual gains apply only at frameStart
        awbEn = 1'b0;
        manRedGain = 8'h11; manGreGain = 8'h22; manBluGain = 8'h33;
        idle(3);
        check("manual_wait_fs", {8'h0, redGain, greGain, bluGain}, 32'h0020_8080);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("manual_applied", {8'h0, redGain, greGain, bluGain}, 32'h0011_2233);

        // 5b. pixel coincident with frameStart is counted: R=4095, gT=0 -> red 0
        awbEn = 1'b1;
        step(1'b1, 1'b0, 1'b1, px(0, 4095));
        idle(2);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        wait_gv("gv_latency_t5");
        check("manual_held_awb_no_pend", {8'h0, redGain, greGain, bluGain}, 32'h0011_2233);
        // 5c. this frame: R=4095 on frameStart, G=4095 on frameEnd -> 2047*128/4095 = 63
        step(1'b1, 1'b0, 1'b1, px(0, 4095));
        idle(1);
        check("gains_one_pixel", {8'h0, redGain, greGain, bluGain}, 32'h0000_8080);
        idle(1);
        step(1'b0, 1'b1, 1'b1, px(1, 4095));
        wait_gv("gv_latency_t5c");
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("gains_coincident", {8'h0, redGain, greGain, bluGain}, 32'h003f_8080);

        // 6. asynchronous reset mid-DIV_R, then a clean frame
        std_frame(2000, 1000, 4000);
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gains", {8'h0, redGain, greGain, bluGain}, 32'h0080_8080);
        check("async_reset_status", {30'h0, busy, gainValid}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        std_frame(2000, 1000, 4000);
        wait_gv("gv_latency_t6");
        step(1'b1, 1'b0, 1'b0, 16'h0);
        idle(1);
        check("gains_after_reset", {8'h0, redGain, greGain, bluGain}, 32'h0040_8020);

        // Randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) awbEn = ~awbEn;
            manRedGain = 8'($urandom);
            manGreGain = 8'($urandom);
            manBluGain = 8'($urandom);
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            len = $urandom_range(3, 30);
            for (int i = 0; i < len; i++)
                step(1'b0, 1'b0, $urandom_range(0, 3) != 0, 16'($urandom));
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            gap = $urandom_range(0, 30);
            for (int i = 0; i < gap; i++) begin
                if ($urandom_range(0, 19) == 0) awbEn = ~awbEn;
                step(1'b0, $urandom_range(0, 9) == 0, 1'b0, 16'h0);
            end
        end
        idle(25);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
